spike_accumulate_scheduler: RTL and testbench
=============================================

Name: spike_accumulate_scheduler

Overview:
- Time-multiplexes one saturating accumulator across all destination neurons of an N-node matrix. This replaces the per-pair `add_if_enabled` crossbar, so adder count no longer grows as N².
- Per spike event, for each destination d, serially sums `weight[d][s]` over every spiking source s ≠ d.
- Streams each result out over a valid/ready handshake to the neuron update stage.
- Holds the N×N weight table, written through a simple write port.

Parameters:
- N, 4, number of neurons (≥2, power of two).
- DATA_W, 8, unsigned weight width.
- ACC_W, 10, unsigned accumulator/result width (≥ DATA_W).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  weight write strobe.
- wr_dst  input  $clog2(N)  destination index of write.
- wr_src  input  $clog2(N)  source index of write.
- wr_data  input  DATA_W  weight value.
- start  input  1  begin one accumulation pass.
- spikes  input  N  spike flags, bit s = source s fired; sampled with start.
- busy  output  1  pass in progress.
- out_valid  output  1  out_dst/out_sum valid.
- out_ready  input  1  downstream accepts result.
- out_dst  output  $clog2(N)  destination index of result.
- out_sum  output  ACC_W  accumulated input for out_dst.
- done  output  1  one-cycle pulse, pass complete.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset.
- Reset values: busy=0, out_valid=0, out_dst=0, out_sum=0, done=0, FSM=IDLE, counters=0.
  - Weight table is cleared to 0.
  - Reset mid-pass aborts immediately; no further out_valid or done.
- Weight writes:
  - `weight[wr_dst][wr_src] <= wr_data` at an edge with wr_en=1 and FSM in IDLE.
  - Writes while busy are ignored (table is stable for a whole pass).
  - The diagonal may be written but is never used.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - At an edge with start=1, latch spikes into spk_q, set dst=0, src=0, acc=0 and go to SCAN. busy=1 from that edge.
- SCAN:
  - At each edge, if `spk_q[src] && src != dst`, then `acc <= sat(acc + weight[dst][src])`; otherwise acc holds.
  - src increments each edge.
  - At src==N-1, go to EMIT, with out_sum = final acc and out_dst = dst.
  - Exactly N cycles per destination, independent of spike pattern.
- EMIT:
  - out_valid=1; out_dst/out_sum are held stable until the handshake.
  - At an edge with out_ready=1:
    - If dst==N-1, go to DONE.
    - Otherwise dst++, src=0, acc=0, go to SCAN.
  - out_valid drops the cycle after acceptance.
- DONE:
  - done=1 for exactly one cycle, then IDLE with busy=0.
- Saturation: `sat(x) = min(x, 2^ACC_W-1)`; no wrap-around. The sum is computed at ACC_W+1 bits.
- Latency (start sampled at edge t, out_ready held 1):
  - First out_valid visible after edge t+N.
  - Each destination takes N+1 cycles.
  - Last handshake at edge t+N·(N+1).
  - done high in the following cycle; busy low after edge t+N·(N+1)+1.
- start while busy (SCAN/EMIT/DONE) is ignored and not queued. The spikes input is don't-care outside the start edge.
- spikes=0 still runs the full pass and emits N results of 0.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- Basic pass:
  - Setup: N=4; write `weight[d][s] = 10·d + s + 1` for all d,s; start with spikes=4'b0101, out_ready=1.
  - Required results: (dst0, 3), (dst1, 24), (dst2, 21), (dst3, 64).
  - Required timing: first out_valid 4 cycles after start; done exactly one cycle after the 4th handshake (edge +20); busy low after.
- Self-connection excluded:
  - Setup: spikes=4'b0001, all weights 7.
  - Required results: dst0=0, dst1=7, dst2=7, dst3=7.
- Saturation:
  - Setup: ACC_W=8, all weights 255, spikes=4'b1111.
  - Required results: every out_sum=255, with no wrap.
  - With default ACC_W=10 the same stimulus gives every out_sum=765.
- Backpressure:
  - Setup: hold out_ready=0 for 5 cycles during dst1 EMIT.
  - Required: out_valid stays 1 with out_dst=1, out_sum=24 unchanged; the pass resumes after the accept.
  - Required: total pass length grows by exactly 5 cycles.
- Ignored events:
  - Stimulus: mid-pass, assert start with spikes=4'b1111 and write `weight[3][0]=99`.
  - Required: results match the basic pass; no second pass runs.
  - Required: after done, a readback pass shows the write was dropped (dst3=64).
- Reset mid-pass:
  - Stimulus: assert reset during dst2 SCAN.
  - Required: busy/out_valid/done go to 0 the next edge; the weight table reads all 0 (a new pass returns zeros); no stale done pulse.

Source files
------------

// File: rtl/spike_accumulate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spike_accumulate_scheduler
// Purpose  : Shares one saturating accumulator across every destination
//            neuron of an N-node weight matrix. For each destination d it
//            serially sums weight[d][s] over all spiking sources s != d.
//            Each result is then offered to the neuron update stage over a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        : clock, all logic on the rising edge
//   reset_i      : synchronous, active-high reset; also clears the weight table
//   wr_en_i      : weight write strobe, honoured only while idle
//   wr_dst_i     : destination index of the write
//   wr_src_i     : source index of the write
//   wr_data_i    : weight value (unsigned)
//   start_i      : begin one accumulation pass, honoured only while idle
//   spikes_i     : spike flags, bit s = source s fired; sampled with start_i
//   busy_o       : a pass is in progress
//   out_valid_o  : out_dst_o / out_sum_o hold a result
//   out_ready_i  : downstream accepts the result
//   out_dst_o    : destination index of the result
//   out_sum_o    : saturated accumulated input for out_dst_o
//   done_o       : one-cycle pulse once the last result has been accepted
// ============================================================================
module spike_accumulate_scheduler #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 10
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      wr_en_i,
  input  logic [$clog2(N)-1:0]      wr_dst_i,
  input  logic [$clog2(N)-1:0]      wr_src_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      start_i,
  input  logic [N-1:0]              spikes_i,
  output logic                      busy_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [$clog2(N)-1:0]      out_dst_o,
  output logic [ACC_W-1:0]          out_sum_o,
  output logic                      done_o
);

  localparam int IDX_W = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [N-1:0]      spk_q,   spk_d;
  logic [IDX_W-1:0]  dst_q,   dst_d;
  logic [IDX_W-1:0]  src_q,   src_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [IDX_W-1:0]  odst_q,  odst_d;
  logic [ACC_W-1:0]  osum_q,  osum_d;

  logic [DATA_W-1:0] weight_q [N][N];

  // --------------------------------------------------------------------------
  // Datapath: one saturating add per cycle
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_sel;
  logic              w_use;
  logic [DATA_W-1:0] w_add;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_next;

  always_comb begin
    w_sel = weight_q[dst_q][src_q];
    // A neuron never feeds itself, whatever sits on the diagonal.
    w_use = spk_q[src_q] && (src_q != dst_q);
    w_add = w_use ? w_sel : '0;
    // One guard bit catches overflow; clamp instead of wrapping.
    w_sum = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, w_add};
    w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    spk_d   = spk_q;
    dst_d   = dst_q;
    src_d   = src_q;
    acc_d   = acc_q;
    odst_d  = odst_q;
    osum_d  = osum_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          spk_d   = spikes_i;
          dst_d   = '0;
          src_d   = '0;
          acc_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        // Every source slot costs one cycle, spiking or not, so the pass
        // length is independent of the spike pattern.
        acc_d = w_acc_next;
        src_d = src_q + ONE_IDX;
        if (src_q == LAST_IDX) begin
          osum_d  = w_acc_next;
          odst_d  = dst_q;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (out_ready_i) begin
          if (dst_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            dst_d   = dst_q + ONE_IDX;
            src_d   = '0;
            acc_d   = '0;
            state_d = S_SCAN;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      spk_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      acc_q   <= '0;
      odst_q  <= '0;
      osum_q  <= '0;
    end else begin
      state_q <= state_d;
      spk_q   <= spk_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      acc_q   <= acc_d;
      odst_q  <= odst_d;
      osum_q  <= osum_d;
    end
  end

  // --------------------------------------------------------------------------
  // Weight table: writable only while idle so a pass sees a frozen table.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int d = 0; d < N; d++) begin
        for (int s = 0; s < N; s++) begin
          weight_q[d][s] <= '0;
        end
      end
    end else if (wr_en_i && (state_q == S_IDLE)) begin
      weight_q[wr_dst_i][wr_src_i] <= wr_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decode directly from state so reset clears them on the same edge.
  // --------------------------------------------------------------------------
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_EMIT);
  assign done_o      = (state_q == S_DONE);
  assign out_dst_o   = odst_q;
  assign out_sum_o   = osum_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_accumulate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_accumulate_scheduler
// Purpose  : Self-checking bench for spike_accumulate_scheduler. Two copies of
//            the design (ACC_W=10 and ACC_W=8) share one stimulus stream;
//            expected results are queued at start and compared on handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_accumulate_scheduler;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_dst;
  logic [1:0] wr_src;
  logic [7:0] wr_data;
  logic       start;
  logic [3:0] spikes;
  logic       out_ready;

  logic       busy, out_valid, done;
  logic [1:0] out_dst;
  logic [9:0] out_sum;

  logic       busy8, out_valid8, done8;
  logic [1:0] out_dst8;
  logic [7:0] out_sum8;

  int total = 0;
  int bad   = 0;

  spike_accumulate_scheduler #(.N(N), .DATA_W(8), .ACC_W(10)) dut (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_dst_i(wr_dst),
    .wr_src_i(wr_src), .wr_data_i(wr_data), .start_i(start), .spikes_i(spikes),
    .busy_o(busy), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_dst_o(out_dst), .out_sum_o(out_sum), .done_o(done)
  );

  spike_accumulate_scheduler #(.N(N), .DATA_W(8), .ACC_W(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_dst_i(wr_dst),
    .wr_src_i(wr_src), .wr_data_i(wr_data), .start_i(start), .spikes_i(spikes),
    .busy_o(busy8), .out_valid_o(out_valid8), .out_ready_i(out_ready),
    .out_dst_o(out_dst8), .out_sum_o(out_sum8), .done_o(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0] dst;
    logic [9:0] s10;
    logic [7:0] s8;
  } sb_t;
  sb_t sbq[$];

  task automatic push_exp(input logic [3:0][9:0] e10, input logic [3:0][7:0] e8);
    sb_t e;
    for (int d = 0; d < N; d++) begin
      e.dst = 2'(d);
      e.s10 = e10[d];
      e.s8  = e8[d];
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (out_valid && out_ready) begin
      check("out_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("out_dst", 32'(out_dst), 32'(e.dst));
        check("out_sum", 32'(out_sum), 32'(e.s10));
        check("out8_valid", 32'(out_valid8), 32'd1);
        check("out8_dst", 32'(out_dst8), 32'(e.dst));
        check("out8_sum", 32'(out_sum8), 32'(e.s8));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]       wmode;   // 0: 10*d+s+1, 1: all 7, 2: all 255
    logic [3:0]       spk;
    logic [3:0][9:0]  e10;
    logic [3:0][7:0]  e8;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [7:0] wval(input logic [1:0] mode, input int d, input int s);
    case (mode)
      2'd0:    wval = 8'(10 * d + s + 1);
      2'd1:    wval = 8'd7;
      default: wval = 8'd255;
    endcase
  endfunction

  task automatic program_weights(input logic [1:0] mode);
    for (int d = 0; d < N; d++) begin
      for (int s = 0; s < N; s++) begin
        wr_en   = 1'b1;
        wr_dst  = 2'(d);
        wr_src  = 2'(s);
        wr_data = wval(mode, d, s);
        @(posedge clk); #1;
      end
    end
    wr_en = 1'b0;
  endtask

  // Runs one pass; k counts edges after the start edge. Optional stall of
  // 5 cycles on dst1 and optional injection of start/write at edge ign_k.
  task automatic run_pass(input logic [3:0] spk, input bit bp, input int ign_k,
                          output int first_k, output int done_k);
    int k;
    int hold;
    bit bp_used;
    k = 0; hold = 0; bp_used = 0;
    first_k = -1; done_k = -1;
    start = 1'b1; spikes = spk;
    @(posedge clk); #1;
    start = 1'b0; spikes = 4'($urandom);
    while (k < 200 && done_k < 0) begin
      @(posedge clk); k++; #1;
      start = 1'b0; wr_en = 1'b0;
      if (out_valid && first_k < 0) first_k = k;
      if (hold > 0) begin
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_dst", 32'(out_dst), 32'd1);
        check("bp_sum", 32'(out_sum), 32'd24);
        hold--;
        if (hold == 0) out_ready = 1'b1;
      end
      if (bp && !bp_used && out_valid && out_dst == 2'd1) begin
        out_ready = 1'b0; hold = 5; bp_used = 1;
      end
      if (k == ign_k) begin
        start = 1'b1; spikes = 4'b1111;
        wr_en = 1'b1; wr_dst = 2'd3; wr_src = 2'd0; wr_data = 8'd99;
      end
      if (done) done_k = k;
    end
    check("pass_timeout", 32'(done_k >= 0), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_low_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int fk, dk;
    bit seen;
    reset = 1'b1; wr_en = 1'b0; wr_dst = '0; wr_src = '0; wr_data = '0;
    start = 1'b0; spikes = '0; out_ready = 1'b1;

    tbl[0] = {2'd0, 4'b0101, {10'd64, 10'd21, 10'd24, 10'd3},    {8'd64, 8'd21, 8'd24, 8'd3}};
    tbl[1] = {2'd0, 4'b1111, {10'd96, 10'd67, 10'd38, 10'd9},    {8'd96, 8'd67, 8'd38, 8'd9}};
    tbl[2] = {2'd0, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd0},       {8'd0, 8'd0, 8'd0, 8'd0}};
    tbl[3] = {2'd1, 4'b0001, {10'd7, 10'd7, 10'd7, 10'd0},       {8'd7, 8'd7, 8'd7, 8'd0}};
    tbl[4] = {2'd2, 4'b1111, {10'd765, 10'd765, 10'd765, 10'd765}, {8'd255, 8'd255, 8'd255, 8'd255}};
    tbl[5] = {2'd2, 4'b1010, {10'd255, 10'd510, 10'd255, 10'd510}, {8'd255, 8'd255, 8'd255, 8'd255}};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_dst", 32'(out_dst), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Table-driven passes
    for (int i = 0; i < 6; i++) begin
      program_weights(tbl[i].wmode);
      push_exp(tbl[i].e10, tbl[i].e8);
      run_pass(tbl[i].spk, 1'b0, -1, fk, dk);
      check("first_valid_lat", 32'(fk), 32'd4);
      check("done_lat", 32'(dk), 32'd20);
    end
    check("sb_empty_table", 32'(sbq.size()), 32'd0);

    // Backpressure on dst1 for 5 cycles
    program_weights(2'd0);
    push_exp(tbl[0].e10, tbl[0].e8);
    run_pass(4'b0101, 1'b1, -1, fk, dk);
    check("bp_first_valid", 32'(fk), 32'd4);
    check("bp_done_lat", 32'(dk), 32'd25);

    // Start and weight write while busy are both dropped
    push_exp(tbl[0].e10, tbl[0].e8);
    run_pass(4'b0101, 1'b0, 6, fk, dk);
    check("ign_done_lat", 32'(dk), 32'd20);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || out_valid || done) seen = 1;
    end
    check("no_second_pass", 32'(seen), 32'd0);
    push_exp(tbl[0].e10, tbl[0].e8);
    run_pass(4'b0101, 1'b0, -1, fk, dk);
    check("readback_done_lat", 32'(dk), 32'd20);
    check("sb_empty_ign", 32'(sbq.size()), 32'd0);

    // Reset during dst2 SCAN
    push_exp(tbl[0].e10, tbl[0].e8);
    start = 1'b1; spikes = 4'b0101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_pending", 32'(sbq.size()), 32'd2);
    sbq.delete();
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy || out_valid || done) seen = 1;
    end
    check("no_stale_activity", 32'(seen), 32'd0);
    push_exp('0, '0);
    run_pass(4'b1111, 1'b0, -1, fk, dk);
    check("zero_pass_done_lat", 32'(dk), 32'd20);
    check("sb_empty_final", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
